fifo_wr_arbiter: RTL

//  Packet-aware round-robin arbiter sharing the write side of one sync_fifo among NUM_REQ sources.

---
 rtl/fifo_wr_arbiter_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared configuration and FSM encoding for the packet-aware FIFO write arbiter.
package fifo_wr_arbiter_pkg;

   localparam int CFG_ARB_NUM_REQ   = 4;
   localparam int CFG_ARB_MAX_BURST = 16;

   typedef enum logic {
      ARB_ST_IDLE  = 1'b0,
      ARB_ST_GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr_i, wrapping to the lowest set request.
module fifo_wr_arbiter_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] grant_oh_o,
   output logic [IDW-1:0]     grant_idx_o
);

   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] masked;
   logic [NUM_REQ-1:0] sel;
   logic               found;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
         assign mask[gi] = (IDW'(gi) >= ptr_i);
      end
   endgenerate

   assign masked = req_i & mask;

   // Masked encoder wins when anything sits at/after the pointer; otherwise wrap around.
   always_comb begin
      sel         = (|masked) ? masked : req_i;
      grant_oh_o  = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel[i] && !found) begin
            found          = 1'b1;
            grant_oh_o[i]  = 1'b1;
            grant_idx_o    = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter in front of a sync FIFO write port; holds a grant until
// packet end or MAX_BURST beats, and only starts new grants while the FIFO is not almost-full.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = CFG_ARB_NUM_REQ,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = CFG_ARB_MAX_BURST,
   parameter int IDW        = $clog2(NUM_REQ),
   parameter int BCW        = $clog2(MAX_BURST + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          o_valid_s,
   output logic [DATA_WIDTH-1:0]         o_data,
   input  logic                          i_ready_s,
   input  logic                          i_almostfull,
   output logic [IDW-1:0]                o_grant_id,
   output logic                          o_busy,
   output logic                          o_pkt_done
);

   arb_state_e         state_q,     state_d;
   logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
   logic [BCW-1:0]     burst_cnt_q, burst_cnt_d;
   logic [IDW-1:0]     grant_id_q,  grant_id_d;
   logic [NUM_REQ-1:0] grant_oh_q,  grant_oh_d;
   logic               pkt_done_q,  pkt_done_d;

   logic [NUM_REQ-1:0]    pick_oh;
   logic [IDW-1:0]        pick_idx;
   logic                  busy;
   logic                  owner_valid;
   logic                  beat_acc;
   logic                  beat_last;
   logic                  burst_end;
   logic [DATA_WIDTH-1:0] src_data [NUM_REQ];

   fifo_wr_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_pick (
      .req_i       (req_valid),
      .ptr_i       (rr_ptr_q),
      .grant_oh_o  (pick_oh),
      .grant_idx_o (pick_idx)
   );

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
         assign src_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign busy        = (state_q == ARB_ST_GRANT);
   assign owner_valid = |(req_valid & grant_oh_q);
   assign beat_acc    = busy && owner_valid && i_ready_s;
   assign beat_last   = |(req_last & grant_oh_q);
   assign burst_end   = (burst_cnt_q == BCW'(MAX_BURST - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB_ST_IDLE;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         grant_id_q  <= '0;
         grant_oh_q  <= '0;
         pkt_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         grant_id_q  <= grant_id_d;
         grant_oh_q  <= grant_oh_d;
         pkt_done_q  <= pkt_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      grant_id_d  = grant_id_q;
      grant_oh_d  = grant_oh_q;
      pkt_done_d  = 1'b0;
      case (state_q)
         ARB_ST_IDLE: begin
            if (|req_valid && !i_almostfull) begin
               state_d     = ARB_ST_GRANT;
               grant_id_d  = pick_idx;
               grant_oh_d  = pick_oh;
               burst_cnt_d = '0;
            end
         end
         ARB_ST_GRANT: begin
            if (beat_acc) begin
               burst_cnt_d = burst_cnt_q + BCW'(1);
               // The pointer moves past the owner only when its grant closes.
               if (beat_last || burst_end) begin
                  state_d    = ARB_ST_IDLE;
                  pkt_done_d = 1'b1;
                  rr_ptr_d   = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_ST_IDLE;
      endcase
   end

   assign o_busy     = busy;
   assign o_pkt_done = pkt_done_q;
   assign o_grant_id = grant_id_q;
   assign o_valid_s  = busy && owner_valid;
   assign req_ready  = busy ? (grant_oh_q & {NUM_REQ{i_ready_s}}) : '0;
   assign o_data     = src_data[grant_id_q];

endmodule
